// File: rtl/adder_pkg.sv
// Shared definitions for the sequential multi-word adder.
//   state_t        : limb-sequencer FSM states (IDLE, BUSY)
//   SIZE_DEFAULT   : default limb width in bits
//   WORDS_DEFAULT  : default number of limbs per operand
package adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int SIZE_DEFAULT  = 4;
  localparam int WORDS_DEFAULT = 4;

endpackage

// File: rtl/limb_adder.sv
// Combinational SIZE-bit generate/propagate ripple adder.
// Ports:
//   a, b   : limb operands (SIZE bits)
//   cin    : carry into bit 0
//   sum    : a + b + cin, low SIZE bits
//   cout   : carry out of the MSB
//   cmsb   : carry into the MSB (for signed-overflow detection)
module limb_adder #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  output logic [SIZE-1:0] sum,
  output logic            cout,
  output logic            cmsb
);

  logic [SIZE-1:0] g;
  logic [SIZE-1:0] p;
  logic [SIZE:0]   c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SIZE; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum  = p ^ c[SIZE-1:0];
    cout = c[SIZE];
    cmsb = c[SIZE-1];
  end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential multi-word adder: operands arrive one SIZE-bit limb per accept,
// least-significant limb first; each limb sum is registered with latency 1.
// Optional feature macro: MULTIWORD_ADD_SEQ_OVF_EN enables the signed-overflow
// flag on the final limb; without it out_ovf is tied to 0.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : synchronous abort of the operand in progress
//   in_valid/in_ready : upstream limb handshake
//   in_a, in_b        : operand limbs
//   in_cin            : carry-in, used on limb 0 only
//   out_valid/out_ready : downstream result handshake
//   out_sum           : registered sum limb
//   out_cout          : carry-out of the held limb
//   out_last          : held limb is limb WORDS-1
//   out_ovf           : signed overflow on the final limb
module multiword_add_seq
  import adder_pkg::*;
#(
  parameter int SIZE  = SIZE_DEFAULT,
  parameter int WORDS = WORDS_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_a,
  input  logic [SIZE-1:0] in_b,
  input  logic            in_cin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_sum,
  output logic            out_cout,
  output logic            out_last,
  output logic            out_ovf
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            carry_q;
  logic            accept;
  logic            first_p0;
  logic            last_p0;
  logic            cin_p0;
  logic [SIZE-1:0] sum_p0;
  logic            cout_p0;
  logic            cmsb_p0;

  assign accept   = in_valid && in_ready;
  assign first_p0 = (cnt_q == '0);
  assign last_p0  = (cnt_q == LAST_IDX);
  // in_cin only matters on limb 0; later limbs chain the stored carry.
  assign cin_p0   = first_p0 ? in_cin : carry_q;

  limb_adder #(.SIZE(SIZE)) u_limb_adder (
    .a    (in_a),
    .b    (in_b),
    .cin  (cin_p0),
    .sum  (sum_p0),
    .cout (cout_p0),
    .cmsb (cmsb_p0)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; with WORDS==1 limb 0 is also the last limb,
  // so the machine never leaves IDLE.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else if (accept) begin
      if (last_p0)       state_d = IDLE;
      else if (first_p0) state_d = BUSY;
    end
  end

  // FSM output logic: accept a new limb whenever the output register is
  // empty or is being drained this cycle.
  always_comb begin
    in_ready = !out_valid || out_ready;
  end

  // Stage p0 -> p1: limb counter, carry chain and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_last  <= 1'b0;
    end else if (flush) begin
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      cnt_q     <= last_p0 ? '0 : cnt_q + CW'(1);
      carry_q   <= cout_p0;
      out_valid <= 1'b1;
      out_sum   <= sum_p0;
      out_cout  <= cout_p0;
      out_last  <= last_p0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MULTIWORD_ADD_SEQ_OVF_EN
  // Signed overflow is only meaningful on the most significant limb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  out_ovf <= 1'b0;
    else if (accept && !flush) out_ovf <= last_p0 & (cmsb_p0 ^ cout_p0);
  end
`else
  logic unused_cmsb;
  assign unused_cmsb = cmsb_p0;
  assign out_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_multiword_add_seq.sv
module tb_multiword_add_seq;

  localparam int SIZE  = 4;
  localparam int WORDS = 4;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] in_a;
  logic [SIZE-1:0] in_b;
  logic            in_cin;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out_sum;
  logic            out_cout;
  logic            out_last;
  logic            out_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multiword_add_seq #(.SIZE(SIZE), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_last  (out_last),
    .out_ovf   (out_ovf)
  );

  // Drive one cycle of inputs, then land #1 after the rising edge.
  task automatic drive(input logic v, input logic [SIZE-1:0] a,
                       input logic [SIZE-1:0] b, input logic cin);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    @(posedge clk);
    #1;
  endtask

  // Observed word: {out_valid, out_sum, out_cout, out_last, out_ovf}
  task automatic test_reset();
    logic [7:0] obs;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs = {out_valid, out_sum, out_cout, out_last, out_ovf};
    n_cmp++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 00", obs);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    rst = 1'b0;
    #1;
  endtask

  // 0xFFFF + 0x0001: every limb sums to 0 with carry-out 1, one per cycle.
  task automatic test_carry_chain();
    logic [15:0] a = 16'hFFFF;
    logic [15:0] b = 16'h0001;
    logic [7:0]  obs, exp;
    for (int i = 0; i < WORDS; i++) begin
      drive(1'b1, a[i*4 +: 4], b[i*4 +: 4], 1'b0);
      obs = {out_valid, out_sum, out_cout, out_last, out_ovf};
      exp = {1'b1, 4'h0, 1'b1, (i == WORDS-1), 1'b0};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL carry_chain_limb%0d: got %h expected %h", i, obs, exp);
      end
    end
    drive(1'b0, '0, '0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL carry_chain_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  // 0x7FFF + 0x0001 = 0x8000: positive + positive gives a negative result.
  task automatic test_overflow();
    logic [15:0] a = 16'h7FFF;
    logic [15:0] b = 16'h0001;
    logic [3:0]  sums [4] = '{4'h0, 4'h0, 4'h0, 4'h8};
    logic [3:0]  couts = 4'b0111;
    logic [7:0]  obs, exp;
    for (int i = 0; i < WORDS; i++) begin
      drive(1'b1, a[i*4 +: 4], b[i*4 +: 4], 1'b0);
      obs = {out_valid, out_sum, out_cout, out_last, out_ovf};
      exp = {1'b1, sums[i], couts[i], (i == WORDS-1),
             (i == WORDS-1) ? OVF_EXP : 1'b0};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL overflow_limb%0d: got %h expected %h", i, obs, exp);
      end
    end
    drive(1'b0, '0, '0, 1'b0);
  endtask

  // Stall after limb 0 (F+F = E, carry 1), then resume: 1+0+carry = 2.
  task automatic test_backpressure();
    logic [7:0] obs, exp;
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 4'h1; in_b = 4'h0; in_cin = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_in_ready_c%0d: got %b expected 0", i, in_ready);
      end
      obs = {out_valid, out_sum, out_cout, out_last, out_ovf};
      n_cmp++;
      if (obs !== {1'b1, 4'hE, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold_c%0d: got %h expected %h", i, obs,
                 {1'b1, 4'hE, 1'b1, 1'b0, 1'b0});
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drive(1'b1, 4'h1, 4'h0, 1'b0);
    exp = {1'b1, 4'h2, 1'b0, 1'b0, 1'b0};
    obs = {out_valid, out_sum, out_cout, out_last, out_ovf};
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL resume_limb1: got %h expected %h", obs, exp);
    end
    drive(1'b1, 4'h0, 4'h0, 1'b0);
    drive(1'b1, 4'h0, 4'h0, 1'b0);
    exp = {1'b1, 4'h0, 1'b0, 1'b1, 1'b0};
    obs = {out_valid, out_sum, out_cout, out_last, out_ovf};
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL resume_limb3: got %h expected %h", obs, exp);
    end
    drive(1'b0, '0, '0, 1'b0);
  endtask

  // Flush after two limbs (with a same-cycle limb that must be dropped),
  // then 0x0003 + 0x0004 + cin 1; in_cin on later limbs must be ignored.
  task automatic test_flush();
    logic [3:0] sums [4] = '{4'h8, 4'h0, 4'h0, 4'h0};
    logic [7:0] obs, exp;
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    flush = 1'b1;
    drive(1'b1, 4'h9, 4'h9, 1'b1);
    flush = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clears_valid: got %b expected 0", out_valid);
    end
    for (int i = 0; i < WORDS; i++) begin
      drive(1'b1, (i == 0) ? 4'h3 : 4'h0, (i == 0) ? 4'h4 : 4'h0, 1'b1);
      obs = {out_valid, out_sum, out_cout, out_last, out_ovf};
      exp = {1'b1, sums[i], 1'b0, (i == WORDS-1), 1'b0};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL post_flush_limb%0d: got %h expected %h", i, obs, exp);
      end
    end
    drive(1'b0, '0, '0, 1'b0);
  endtask

  // Reset mid-operand: outputs clear asynchronously, next limb is limb 0.
  task automatic test_reset_mid();
    logic [7:0] obs, exp;
    drive(1'b1, 4'hF, 4'h1, 1'b0);
    drive(1'b1, 4'h5, 4'h5, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    obs = {out_valid, out_sum, out_cout, out_last, out_ovf};
    n_cmp++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %h expected 00", obs);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      drive(1'b1, (i == 0) ? 4'h1 : 4'h0, (i == 0) ? 4'h1 : 4'h0, 1'b1);
      obs = {out_valid, out_sum, out_cout, out_last, out_ovf};
      exp = {1'b1, (i == 0) ? 4'h3 : 4'h0, 1'b0, (i == WORDS-1), 1'b0};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL after_reset_limb%0d: got %h expected %h", i, obs, exp);
      end
    end
    drive(1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_overflow();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
